multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 subset controller: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and strobes, and counts retired instructions.
module multicycle_control #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic [6:0]         funct7,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_src,
   output logic               ir_write,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic               illegal,
   output logic               retire,
   output logic [1:0]         alu_src_b,
   output logic [3:0]         alu_ctl,
   output logic [3:0]         state,
   output logic [COUNT_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t state_r;
   state_t state_nx;

   logic is_add;
   logic is_sub;
   logic is_and;
   logic is_or;
   logic r_legal;

   // R-type function decode; opcode is held stable through the instruction
   assign is_add  = (opcode == OP_R) && ({funct7, funct3} == {7'b0000000, 3'b000});
   assign is_sub  = (opcode == OP_R) && ({funct7, funct3} == {7'b0100000, 3'b000});
   assign is_and  = (opcode == OP_R) && ({funct7, funct3} == {7'b0000000, 3'b111});
   assign is_or   = (opcode == OP_R) && ({funct7, funct3} == {7'b0000000, 3'b110});
   assign r_legal = is_add | is_sub | is_and | is_or;

   assign state = state_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_FETCH;
         instret <= '0;
      end else begin
         state_r <= state_nx;
         if (retire)
            instret <= instret + COUNT_W'(1);
      end
   end

   always_comb begin
      state_nx   = state_r;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      illegal    = 1'b0;
      retire     = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctl    = ALU_AND;

      unique case (state_r)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_ctl   = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_ctl   = ALU_ADD;
            if (r_legal)
               state_nx = S_EXEC_R;
            else if ((opcode == OP_I) && (funct3 == 3'b000))
               state_nx = S_EXEC_I;
            else if (((opcode == OP_LOAD) || (opcode == OP_STORE)) && (funct3 == 3'b010))
               state_nx = S_MEM_ADDR;
            else if ((opcode == OP_BRANCH) && (funct3 == 3'b000))
               state_nx = S_BRANCH;
            else
               state_nx = S_TRAP;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            if (is_sub)
               alu_ctl = ALU_SUB;
            else if (is_and)
               alu_ctl = ALU_AND;
            else if (is_or)
               alu_ctl = ALU_OR;
            else
               alu_ctl = ALU_ADD;
            state_nx = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctl   = ALU_ADD;
            state_nx  = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_nx  = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctl   = ALU_ADD;
            state_nx  = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready)
               state_nx = S_WB_MEM;
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_nx   = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               retire   = 1'b1;
               state_nx = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            alu_ctl   = ALU_SUB;
            pc_src    = 1'b1;
            pc_write  = zero;
            retire    = 1'b1;
            state_nx  = S_FETCH;
         end
         S_TRAP: begin
            illegal  = 1'b1;
            state_nx = S_TRAP;
         end
         // Unused encodings are treated as a corrupted controller
         default: begin
            state_nx = S_TRAP;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand sequences
// for memory waits, trap hold, reset mid-store and instret wrap (COUNT_W=4).
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write;
   logic       reg_write, mem_to_reg, alu_src_a, illegal, retire;
   logic [1:0] alu_src_b;
   logic [3:0] alu_ctl;
   logic [3:0] state;
   logic [3:0] instret;

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_control #(.COUNT_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
      .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .illegal(illegal), .retire(retire), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
      .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   // strobe order: pc_write pc_src ir_write iord mem_read mem_write reg_write mem_to_reg alu_src_a illegal retire
   localparam logic [10:0] SB_FETCH   = 11'b00001000000;
   localparam logic [10:0] SB_FETCHR  = 11'b10101000000;
   localparam logic [10:0] SB_NONE    = 11'b00000000000;
   localparam logic [10:0] SB_EXEC    = 11'b00000000100;
   localparam logic [10:0] SB_WBALU   = 11'b00000010001;
   localparam logic [10:0] SB_MEMRD   = 11'b00011000000;
   localparam logic [10:0] SB_WBMEM   = 11'b00000011001;
   localparam logic [10:0] SB_MEMWR   = 11'b00010100000;
   localparam logic [10:0] SB_MEMWRR  = 11'b00010100001;
   localparam logic [10:0] SB_BRTAKEN = 11'b11000000101;
   localparam logic [10:0] SB_BRNOT   = 11'b01000000101;
   localparam logic [10:0] SB_TRAP    = 11'b00000000010;

   localparam logic [6:0] R  = 7'b0110011;
   localparam logic [6:0] I  = 7'b0010011;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] BR = 7'b1100011;
   localparam logic [6:0] SY = 7'b1110011;

   typedef struct {
      logic        chk;
      logic        rst;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        zr;
      logic        mr;
      logic [3:0]  st;
      logic [10:0] sb;
      logic [1:0]  srcb;
      logic [3:0]  alu;
      logic [3:0]  ir;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic chk, logic r, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                               logic zr, logic mr, logic [3:0] st, logic [10:0] sb,
                               logic [1:0] srcb, logic [3:0] alu, logic [3:0] ir);
      vec_t v;
      v.chk = chk; v.rst = r; v.op = op; v.f3 = f3; v.f7 = f7; v.zr = zr; v.mr = mr;
      v.st = st; v.sb = sb; v.srcb = srcb; v.alu = alu; v.ir = ir;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic zr, input logic mr);
      @(negedge clk);
      rst = r; opcode = op; funct3 = f3; funct7 = f7; zero = zr; mem_ready = mr;
      #1;
   endtask

   function automatic logic [10:0] strobes();
      return {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
              reg_write, mem_to_reg, alu_src_a, illegal, retire};
   endfunction

   // one full ADDI instruction starting in FETCH, no memory stalls
   task automatic run_addi();
      drive(0, I, 3'b000, 7'd0, 0, 1);
      drive(0, I, 3'b000, 7'd0, 0, 0);
      drive(0, I, 3'b000, 7'd0, 0, 0);
      drive(0, I, 3'b000, 7'd0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0; mem_ready = 1'b0;

      tbl.push_back(mk(0, 1, R, 3'b000, 7'd0, 0, 0, 4'd0, SB_FETCH, 2'b01, 4'b0010, 4'd0));
      tbl.push_back(mk(1, 0, R, 3'b000, 7'd0, 0, 0, 4'd0, SB_FETCH, 2'b01, 4'b0010, 4'd0));
      // ADD
      tbl.push_back(mk(1, 0, R, 3'b000, 7'd0, 0, 1, 4'd0, SB_FETCHR, 2'b01, 4'b0010, 4'd0));
      tbl.push_back(mk(1, 0, R, 3'b000, 7'd0, 0, 0, 4'd1, SB_NONE,   2'b11, 4'b0010, 4'd0));
      tbl.push_back(mk(1, 0, R, 3'b000, 7'd0, 0, 0, 4'd2, SB_EXEC,   2'b00, 4'b0010, 4'd0));
      tbl.push_back(mk(1, 0, R, 3'b000, 7'd0, 0, 0, 4'd7, SB_WBALU,  2'b00, 4'b0000, 4'd0));
      // SUB
      tbl.push_back(mk(1, 0, R, 3'b000, 7'h20, 0, 1, 4'd0, SB_FETCHR, 2'b01, 4'b0010, 4'd1));
      tbl.push_back(mk(1, 0, R, 3'b000, 7'h20, 0, 0, 4'd1, SB_NONE,   2'b11, 4'b0010, 4'd1));
      tbl.push_back(mk(1, 0, R, 3'b000, 7'h20, 0, 0, 4'd2, SB_EXEC,   2'b00, 4'b0110, 4'd1));
      tbl.push_back(mk(1, 0, R, 3'b000, 7'h20, 0, 0, 4'd7, SB_WBALU,  2'b00, 4'b0000, 4'd1));
      // AND
      tbl.push_back(mk(1, 0, R, 3'b111, 7'd0, 0, 1, 4'd0, SB_FETCHR, 2'b01, 4'b0010, 4'd2));
      tbl.push_back(mk(1, 0, R, 3'b111, 7'd0, 0, 0, 4'd1, SB_NONE,   2'b11, 4'b0010, 4'd2));
      tbl.push_back(mk(1, 0, R, 3'b111, 7'd0, 0, 0, 4'd2, SB_EXEC,   2'b00, 4'b0000, 4'd2));
      tbl.push_back(mk(1, 0, R, 3'b111, 7'd0, 0, 0, 4'd7, SB_WBALU,  2'b00, 4'b0000, 4'd2));
      // OR
      tbl.push_back(mk(1, 0, R, 3'b110, 7'd0, 0, 1, 4'd0, SB_FETCHR, 2'b01, 4'b0010, 4'd3));
      tbl.push_back(mk(1, 0, R, 3'b110, 7'd0, 0, 0, 4'd1, SB_NONE,   2'b11, 4'b0010, 4'd3));
      tbl.push_back(mk(1, 0, R, 3'b110, 7'd0, 0, 0, 4'd2, SB_EXEC,   2'b00, 4'b0001, 4'd3));
      tbl.push_back(mk(1, 0, R, 3'b110, 7'd0, 0, 0, 4'd7, SB_WBALU,  2'b00, 4'b0000, 4'd3));
      // ADDI
      tbl.push_back(mk(1, 0, I, 3'b000, 7'd0, 0, 1, 4'd0, SB_FETCHR, 2'b01, 4'b0010, 4'd4));
      tbl.push_back(mk(1, 0, I, 3'b000, 7'd0, 0, 0, 4'd1, SB_NONE,   2'b11, 4'b0010, 4'd4));
      tbl.push_back(mk(1, 0, I, 3'b000, 7'd0, 0, 0, 4'd3, SB_EXEC,   2'b10, 4'b0010, 4'd4));
      tbl.push_back(mk(1, 0, I, 3'b000, 7'd0, 0, 0, 4'd7, SB_WBALU,  2'b00, 4'b0000, 4'd4));
      // LW with mem_ready=1 in DECODE/MEM_ADDR (ignored), 3 wait cycles in MEM_RD
      tbl.push_back(mk(1, 0, LD, 3'b010, 7'd0, 0, 1, 4'd0, SB_FETCHR, 2'b01, 4'b0010, 4'd5));
      tbl.push_back(mk(1, 0, LD, 3'b010, 7'd0, 0, 1, 4'd1, SB_NONE,   2'b11, 4'b0010, 4'd5));
      tbl.push_back(mk(1, 0, LD, 3'b010, 7'd0, 0, 1, 4'd4, SB_EXEC,   2'b10, 4'b0010, 4'd5));
      tbl.push_back(mk(1, 0, LD, 3'b010, 7'd0, 0, 0, 4'd5, SB_MEMRD,  2'b00, 4'b0000, 4'd5));
      tbl.push_back(mk(1, 0, LD, 3'b010, 7'd0, 0, 0, 4'd5, SB_MEMRD,  2'b00, 4'b0000, 4'd5));
      tbl.push_back(mk(1, 0, LD, 3'b010, 7'd0, 0, 0, 4'd5, SB_MEMRD,  2'b00, 4'b0000, 4'd5));
      tbl.push_back(mk(1, 0, LD, 3'b010, 7'd0, 0, 1, 4'd5, SB_MEMRD,  2'b00, 4'b0000, 4'd5));
      tbl.push_back(mk(1, 0, LD, 3'b010, 7'd0, 0, 0, 4'd8, SB_WBMEM,  2'b00, 4'b0000, 4'd5));
      // BEQ taken then not taken
      tbl.push_back(mk(1, 0, BR, 3'b000, 7'd0, 1, 1, 4'd0, SB_FETCHR,  2'b01, 4'b0010, 4'd6));
      tbl.push_back(mk(1, 0, BR, 3'b000, 7'd0, 1, 0, 4'd1, SB_NONE,    2'b11, 4'b0010, 4'd6));
      tbl.push_back(mk(1, 0, BR, 3'b000, 7'd0, 1, 0, 4'd9, SB_BRTAKEN, 2'b00, 4'b0110, 4'd6));
      tbl.push_back(mk(1, 0, BR, 3'b000, 7'd0, 0, 1, 4'd0, SB_FETCHR,  2'b01, 4'b0010, 4'd7));
      tbl.push_back(mk(1, 0, BR, 3'b000, 7'd0, 0, 0, 4'd1, SB_NONE,    2'b11, 4'b0010, 4'd7));
      tbl.push_back(mk(1, 0, BR, 3'b000, 7'd0, 0, 0, 4'd9, SB_BRNOT,   2'b00, 4'b0110, 4'd7));
      // SW with one wait, then SYSTEM opcode traps
      tbl.push_back(mk(1, 0, ST, 3'b010, 7'd0, 0, 1, 4'd0, SB_FETCHR, 2'b01, 4'b0010, 4'd8));
      tbl.push_back(mk(1, 0, ST, 3'b010, 7'd0, 0, 0, 4'd1, SB_NONE,   2'b11, 4'b0010, 4'd8));
      tbl.push_back(mk(1, 0, ST, 3'b010, 7'd0, 0, 0, 4'd4, SB_EXEC,   2'b10, 4'b0010, 4'd8));
      tbl.push_back(mk(1, 0, ST, 3'b010, 7'd0, 0, 0, 4'd6, SB_MEMWR,  2'b00, 4'b0000, 4'd8));
      tbl.push_back(mk(1, 0, ST, 3'b010, 7'd0, 0, 1, 4'd6, SB_MEMWRR, 2'b00, 4'b0000, 4'd8));
      tbl.push_back(mk(1, 0, SY, 3'b000, 7'd0, 0, 1, 4'd0, SB_FETCHR, 2'b01, 4'b0010, 4'd9));
      tbl.push_back(mk(1, 0, SY, 3'b000, 7'd0, 0, 1, 4'd1, SB_NONE,   2'b11, 4'b0010, 4'd9));
      tbl.push_back(mk(1, 0, SY, 3'b000, 7'd0, 0, 1, 4'd15, SB_TRAP,  2'b00, 4'b0000, 4'd9));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].zr, tbl[i].mr);
         if (tbl[i].chk) begin
            check($sformatf("vec%0d state", i),   32'(state),     32'(tbl[i].st));
            check($sformatf("vec%0d strobes", i), 32'(strobes()), 32'(tbl[i].sb));
            check($sformatf("vec%0d alu_src_b", i), 32'(alu_src_b), 32'(tbl[i].srcb));
            check($sformatf("vec%0d alu_ctl", i), 32'(alu_ctl),   32'(tbl[i].alu));
            check($sformatf("vec%0d instret", i), 32'(instret),   32'(tbl[i].ir));
         end
      end

      // TRAP absorbs for 10 more cycles regardless of mem_ready
      for (int c = 0; c < 10; c++) begin
         drive(0, SY, 3'b000, 7'd0, c[0], 1);
         check("trap_hold state", 32'(state), 32'd15);
         check("trap_hold strobes", 32'(strobes()), 32'(SB_TRAP));
         check("trap_hold instret", 32'(instret), 32'd9);
      end

      // reset out of TRAP, then an illegal R-type funct7 must trap
      drive(1, SY, 3'b000, 7'd0, 0, 1);
      drive(0, R, 3'b000, 7'h01, 0, 0);
      check("rst_from_trap state", 32'(state), 32'd0);
      check("rst_from_trap illegal", 32'(illegal), 32'd0);
      check("rst_from_trap instret", 32'(instret), 32'd0);
      drive(0, R, 3'b000, 7'h01, 0, 1);
      drive(0, R, 3'b000, 7'h01, 0, 0);
      drive(0, R, 3'b000, 7'h01, 0, 0);
      check("bad_funct7 state", 32'(state), 32'd15);
      check("bad_funct7 illegal", 32'(illegal), 32'd1);

      // reset during a MEM_WR wait abandons the store
      drive(1, I, 3'b000, 7'd0, 0, 0);
      run_addi();
      drive(0, ST, 3'b010, 7'd0, 0, 1);
      check("pre_sw instret", 32'(instret), 32'd1);
      drive(0, ST, 3'b010, 7'd0, 0, 0);
      drive(0, ST, 3'b010, 7'd0, 0, 0);
      drive(0, ST, 3'b010, 7'd0, 0, 0);
      check("sw_wait state", 32'(state), 32'd6);
      check("sw_wait mem_write", 32'(mem_write), 32'd1);
      drive(1, ST, 3'b010, 7'd0, 0, 1);
      drive(0, ST, 3'b010, 7'd0, 0, 0);
      check("rst_in_memwr state", 32'(state), 32'd0);
      check("rst_in_memwr mem_write", 32'(mem_write), 32'd0);
      check("rst_in_memwr instret", 32'(instret), 32'd0);
      check("rst_in_memwr strobes", 32'(strobes()), 32'(SB_FETCH));

      // 16 retirements wrap the 4-bit counter back to 0
      for (int k = 0; k < 16; k++) begin
         run_addi();
      end
      drive(0, I, 3'b000, 7'd0, 0, 0);
      check("wrap state", 32'(state), 32'd0);
      check("wrap instret", 32'(instret), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
